// File: rtl/dstack_ctrl_if.sv
// Issue-stage handshake into the data-stack sequencer: one opcode per accepted transfer.
interface dstack_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             op_valid;
    logic             op_ready;
    logic [3:0]       op_code;
    logic [5:0]       op_arg;
    logic [WIDTH-1:0] op_imm;

    modport master (output op_valid, output op_code, output op_arg, output op_imm, input op_ready);
    modport slave  (input op_valid, input op_code, input op_arg, input op_imm, output op_ready);
endinterface

// File: rtl/dstack_ctrl.sv
// Data-stack sequencer: decodes stack opcodes into dstack controls, tracks depth,
// expands DROPN into pop/pop2 steps and latches sticky faults.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | ready for an op; decodes and drives controls on accept
// S_DROPN | issuing remaining DROPN steps from the down-counter
// S_FAULT | op rejected; waits for fault_clear
module dstack_ctrl #(
    parameter int DEPTH_MAG = 7,
    parameter int WIDTH     = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    dstack_ctrl_if.slave         issue,
    input  logic [WIDTH-1:0]     alu_result,
    input  logic [WIDTH-1:0]     stk_top,
    input  logic [WIDTH-1:0]     stk_second,
    input  logic [WIDTH-1:0]     stk_third,
    input  logic [WIDTH-1:0]     stk_rot_val,
    output logic [1:0]           stk_movement,
    output logic [WIDTH-1:0]     stk_next_top,
    output logic                 stk_rotate,
    output logic [5:0]           stk_rot_addr,
    output logic [DEPTH_MAG:0]   depth,
    output logic                 busy,
    output logic                 fault,
    output logic [1:0]           fault_code,
    input  logic                 fault_clear
);
    localparam int DW = DEPTH_MAG + 1;
    localparam int NW = (DW > 7) ? DW + 1 : 8;
    localparam logic [DW-1:0] DEPTH_FULL = DW'(1 << DEPTH_MAG);

    typedef enum logic [1:0] {S_IDLE, S_DROPN, S_FAULT} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] depth_q, depth_nxt;
    logic [5:0]    cnt_q, cnt_nxt;
    logic          fault_q, fault_nxt;
    logic [1:0]    code_q, code_nxt;

    logic [1:0]       dec_mv;
    logic [WIDTH-1:0] dec_nt;
    logic             dec_rot;
    logic [5:0]       dec_ra;
    logic [NW-1:0]    dec_need;
    logic             dec_push;
    logic [1:0]       dec_pops;
    logic             dec_illegal;
    logic [1:0]       dec_fcode;
    logic             accept;
    logic             drop_two;

    assign accept   = issue.op_valid && (state == S_IDLE);
    assign drop_two = (cnt_q >= 6'd2);

    // Opcode decode; DROPN decodes as its first step so the accept cycle is uniform.
    always_comb begin
        dec_mv      = 2'b00;
        dec_nt      = stk_top;
        dec_rot     = 1'b0;
        dec_ra      = 6'd0;
        dec_need    = '0;
        dec_push    = 1'b0;
        dec_pops    = 2'd0;
        dec_illegal = 1'b0;
        case (issue.op_code)
            4'd0: ;
            4'd1: begin dec_mv = 2'b01; dec_nt = issue.op_imm; dec_push = 1'b1; end
            4'd2: begin dec_mv = 2'b01; dec_need = NW'(1); dec_push = 1'b1; end
            4'd3: begin dec_mv = 2'b01; dec_nt = stk_second; dec_need = NW'(2); dec_push = 1'b1; end
            4'd4: begin dec_mv = 2'b10; dec_nt = stk_second; dec_need = NW'(1); dec_pops = 2'd1; end
            4'd5: begin dec_mv = 2'b11; dec_nt = stk_third; dec_need = NW'(2); dec_pops = 2'd2; end
            4'd6: begin dec_nt = stk_rot_val; dec_rot = 1'b1; dec_need = NW'(2); end
            4'd7: begin
                dec_nt   = stk_rot_val;
                dec_rot  = 1'b1;
                dec_ra   = issue.op_arg;
                dec_need = NW'(issue.op_arg) + NW'(2);
            end
            4'd8: begin
                dec_mv   = 2'b01;
                dec_nt   = stk_rot_val;
                dec_ra   = issue.op_arg;
                dec_need = NW'(issue.op_arg) + NW'(2);
                dec_push = 1'b1;
            end
            4'd9:  begin dec_nt = alu_result; dec_need = NW'(1); end
            4'd10: begin dec_mv = 2'b10; dec_nt = alu_result; dec_need = NW'(2); dec_pops = 2'd1; end
            4'd11: begin
                dec_need = NW'(issue.op_arg);
                if (issue.op_arg >= 6'd2) begin
                    dec_mv = 2'b11; dec_nt = stk_third; dec_pops = 2'd2;
                end else if (issue.op_arg == 6'd1) begin
                    dec_mv = 2'b10; dec_nt = stk_second; dec_pops = 2'd1;
                end
            end
            default: dec_illegal = 1'b1;
        endcase

        if (dec_illegal)                            dec_fcode = 2'b11;
        else if (NW'(depth_q) < dec_need)           dec_fcode = 2'b01;
        else if (dec_push && depth_q == DEPTH_FULL) dec_fcode = 2'b10;
        else                                        dec_fcode = 2'b00;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            depth_q <= '0;
            cnt_q   <= 6'd0;
            fault_q <= 1'b0;
            code_q  <= 2'b00;
        end else begin
            state   <= state_nxt;
            depth_q <= depth_nxt;
            cnt_q   <= cnt_nxt;
            fault_q <= fault_nxt;
            code_q  <= code_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        depth_nxt = depth_q;
        cnt_nxt   = cnt_q;
        fault_nxt = fault_q;
        code_nxt  = code_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (dec_fcode != 2'b00) begin
                        state_nxt = S_FAULT;
                        fault_nxt = 1'b1;
                        code_nxt  = dec_fcode;
                    end else begin
                        depth_nxt = depth_q + DW'(dec_push) - DW'(dec_pops);
                        if (issue.op_code == 4'd11 && issue.op_arg > {4'b0, dec_pops}) begin
                            cnt_nxt   = issue.op_arg - {4'b0, dec_pops};
                            state_nxt = S_DROPN;
                        end
                    end
                end
            end
            S_DROPN: begin
                depth_nxt = depth_q - (drop_two ? DW'(2) : DW'(1));
                cnt_nxt   = cnt_q - (drop_two ? 6'd2 : 6'd1);
                if (cnt_q <= 6'd2) state_nxt = S_IDLE;
            end
            S_FAULT: begin
                if (fault_clear) begin
                    state_nxt = S_IDLE;
                    fault_nxt = 1'b0;
                    code_nxt  = 2'b00;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // A rejected op leaves the stack controls at their idle values.
    always_comb begin
        stk_movement   = 2'b00;
        stk_next_top   = stk_top;
        stk_rotate     = 1'b0;
        stk_rot_addr   = 6'd0;
        issue.op_ready = (state == S_IDLE);
        busy           = (state == S_DROPN);
        case (state)
            S_IDLE: begin
                if (accept && dec_fcode == 2'b00) begin
                    stk_movement = dec_mv;
                    stk_next_top = dec_nt;
                    stk_rotate   = dec_rot;
                    stk_rot_addr = dec_ra;
                end
            end
            S_DROPN: begin
                stk_movement = drop_two ? 2'b11 : 2'b10;
                stk_next_top = drop_two ? stk_third : stk_second;
            end
            default: ;
        endcase
    end

    assign depth      = depth_q;
    assign fault      = fault_q;
    assign fault_code = code_q;
endmodule

// File: doc/dstack_ctrl.md
Name: dstack_ctrl

Overview:
Sequencer sitting between instruction issue and the core0 data stack.
Decodes stack opcodes into the dstack's movement / next_top / rotate / rot_addr controls and tracks the true stack depth.
Expands multi-cycle ops (DROPN) into a series of single/double pops, and raises sticky underflow/overflow/illegal-op faults.
Uses a valid/ready handshake with the issue stage.

Parameters:
DEPTH_MAG, 7, log2 of dstack depth
DEPTH, 1 << DEPTH_MAG, usable stack entries (including top)
WIDTH, 32, word width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
op_valid  in  1  issue presents an op
op_ready  out  1  controller can accept an op this cycle
op_code  in  4  opcode (see Behaviour)
op_arg  in  6  n for ROT/COPY/DROPN
op_imm  in  WIDTH  immediate for PUSH
alu_result  in  WIDTH  result for REPLACE/BINOP
stk_top  in  WIDTH  dstack top
stk_second  in  WIDTH  dstack second
stk_third  in  WIDTH  dstack third
stk_rot_val  in  WIDTH  dstack rot_val (element rot_addr+1)
stk_movement  out  2  00 none, 01 push, 10 pop, 11 pop2
stk_next_top  out  WIDTH  value the dstack loads into top
stk_rotate  out  1  dstack rotate strobe
stk_rot_addr  out  6  dstack rotate/read address
depth  out  DEPTH_MAG+1  current live entry count, 0..DEPTH
busy  out  1  multi-cycle op in progress
fault  out  1  sticky fault flag
fault_code  out  2  01 underflow, 10 overflow, 11 illegal opcode
fault_clear  in  1  clears the fault and returns to IDLE

Behaviour:
- Reset: state=IDLE, depth=0, fault=0, fault_code=00, busy=0, op_ready=1.
- Stack outputs when idle/not accepting: movement=00, rotate=0, rot_addr=0, next_top=stk_top.
- Accept occurs when op_valid && op_ready.
- Stack controls are combinational in the accept cycle; the dstack updates at the next edge (1-cycle latency).
- Opcodes: (movement, next_top, rotate/rot_addr, min depth required, depth delta)
  - 0 NOP: 00, top; 0; needs 0; delta 0
  - 1 PUSH: 01, op_imm; 0; needs 0; delta +1
  - 2 DUP: 01, top; 0; needs 1; delta +1
  - 3 OVER: 01, second; 0; needs 2; delta +1
  - 4 DROP: 10, second; 0; needs 1; delta -1
  - 5 DROP2: 11, third; 0; needs 2; delta -2
  - 6 SWAP: 00, stk_rot_val; rotate=1, rot_addr=0; needs 2; delta 0
  - 7 ROT n: 00, stk_rot_val; rotate=1, rot_addr=n; needs n+2; delta 0
  - 8 COPY n: 01, stk_rot_val; rotate=0, rot_addr=n; needs n+2; delta +1
  - 9 REPLACE: 00, alu_result; 0; needs 1; delta 0
  - 10 BINOP: 10, alu_result; 0; needs 2; delta -1
  - 11 DROPN n: multi-cycle; needs n; delta -n
  - 12-15: illegal
- Push-type ops (1, 2, 3, 8) with depth==DEPTH → overflow.
- Fault rules: any fault on accept suppresses the op (controls as idle, depth unchanged), sets fault=1 with fault_code, and moves to FAULT.
- Precedence: illegal > underflow > overflow.
- FAULT state: op_ready=0, controls idle. fault_clear → IDLE, fault=0, code=00; depth is kept.
- DROPN:
  - n=0 behaves as NOP.
  - Otherwise, the accept cycle issues the first step; remaining count is held in a counter.
  - Each step issues 11 (next_top=third) if remaining≥2, else 10 (next_top=second).
  - Total ceil(n/2) cycles. Depth is decremented per step.
  - busy=1 and op_ready=0 from the cycle after accept until the final step completes. op_ready returns to 1 the cycle after the last step.
- Depth arithmetic is unsigned. Underflow/overflow checks prevent wrap, so depth never leaves 0..DEPTH.
- Reset mid-DROPN or in FAULT: immediate return to reset state; the partial pop is not completed.
- fault_clear outside FAULT is ignored. reset has priority over fault_clear.

Test Plan:
- Reset, PUSH imm=5, PUSH imm=7, SWAP → movement 01,01 then rotate=1 rot_addr=0 next_top=stk_rot_val; depth 0→1→2→2.
- DROP on depth 0 → fault=1, code=01, movement=00, op_ready=0. fault_clear → op_ready=1, depth 0.
- Fill to depth=128, PUSH → fault code=10, depth stays 128. DUP at depth 127 → accepted, depth 128.
- Depth 10, DROPN n=5 → movements 11,11,10 on consecutive cycles; busy high for 2 cycles after accept; depth 10→8→6→5.
- Depth 4, ROT n=2 → rotate=1, rot_addr=2, depth 4. ROT n=3 → underflow fault.
- Opcode 13 → code=11. Reset asserted during DROPN n=9 step 2 → next cycle depth=0, busy=0, op_ready=1.
